// File: rtl/sprite_palette_lut_pkg.sv
// Shared types and power-on palette contents for the sprite palette lookup.
// DEFAULT_PAL byte pattern per entry: b={pal,idx}, colour={b, ~b, b^8'h5A}.
package sprite_pal_pkg;

    localparam int DEF_NUM_PAL = 8;
    localparam int DEF_PAL_W   = 3;
    localparam int DEF_IDX_W   = 4;
    localparam int DEF_COLOR_W = 24;

    localparam int TRANSPARENT_IDX = 0;

    typedef enum logic [1:0] {IDLE, FLIP, COPY} state_e;

    typedef logic [DEF_NUM_PAL-1:0][2**DEF_IDX_W-1:0][DEF_COLOR_W-1:0] pal_tbl_t;

    function automatic pal_tbl_t gen_default_pal();
        pal_tbl_t   t;
        logic [7:0] b;
        t = '0;
        for (int p = 0; p < DEF_NUM_PAL; p++) begin
            for (int i = 0; i < 2**DEF_IDX_W; i++) begin
                b = {4'(p), 4'(i)};
                t[DEF_PAL_W'(p)][DEF_IDX_W'(i)] = {b, ~b, b ^ 8'h5A};
            end
        end
        return t;
    endfunction

    localparam pal_tbl_t DEFAULT_PAL = gen_default_pal();

endpackage

// File: rtl/sprite_palette_lut_if.sv
// Host write/commit, frame timing and pixel lookup signals of the palette LUT.
interface sprite_palette_lut_if #(
    parameter int NUM_PAL = 8,
    parameter int IDX_W   = 4,
    parameter int COLOR_W = 24
);
    localparam int PAL_W = $clog2(NUM_PAL);

    logic               i_frame_start;
    logic               i_wr_en;
    logic [PAL_W-1:0]   i_wr_pal;
    logic [IDX_W-1:0]   i_wr_idx;
    logic [COLOR_W-1:0] i_wr_color;
    logic               o_wr_ready;
    logic               i_commit;
    logic               o_busy;
    logic               i_cyc_en;
    logic [7:0]         i_cyc_period;
    logic               i_px_valid;
    logic [PAL_W-1:0]   i_px_pal;
    logic [IDX_W-1:0]   i_px_idx;
    logic               o_px_valid;
    logic [COLOR_W-1:0] o_px_color;
    logic               o_px_opaque;

    modport slave (
        input  i_frame_start, i_wr_en, i_wr_pal, i_wr_idx, i_wr_color, i_commit,
               i_cyc_en, i_cyc_period, i_px_valid, i_px_pal, i_px_idx,
        output o_wr_ready, o_busy, o_px_valid, o_px_color, o_px_opaque
    );

    modport master (
        output i_frame_start, i_wr_en, i_wr_pal, i_wr_idx, i_wr_color, i_commit,
               i_cyc_en, i_cyc_period, i_px_valid, i_px_pal, i_px_idx,
        input  o_wr_ready, o_busy, o_px_valid, o_px_color, o_px_opaque
    );

endinterface

// File: rtl/sprite_palette_lut_ram.sv
// Simple dual-port palette bank: one write port, one registered read port.
// Contents power up from INIT and are deliberately untouched by reset.
module pal_bank_ram #(
    parameter int AW = 7,
    parameter int DW = 24,
    parameter logic [2**AW-1:0][DW-1:0] INIT = '0
) (
    input  logic          i_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [2**AW-1:0][DW-1:0] mem = INIT;

    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sprite_palette_lut.sv
// Double-buffered multi-palette colour LUT with frame-synchronous flip,
// shadow copy-back and per-frame colour cycling; 2-cycle lookup latency.
module sprite_palette_lut
    import sprite_pal_pkg::*;
#(
    parameter int NUM_PAL = 8,
    parameter int IDX_W   = 4,
    parameter int COLOR_W = 24,
    parameter int CYC_LO  = 1,
    parameter int CYC_HI  = 13
) (
    input logic i_clk,
    input logic i_rst_n,
    sprite_palette_lut_if.slave bus
);

    localparam int PAL_W = $clog2(NUM_PAL);
    localparam int N     = NUM_PAL * (2**IDX_W);
    localparam int AW    = PAL_W + IDX_W;
    localparam int CYC_L = CYC_HI - CYC_LO + 1;
    localparam int OFF_W = $clog2(CYC_L);
    localparam int LAT   = 2;

    typedef logic [N-1:0][COLOR_W-1:0] bank_t;

    function automatic bank_t bank_init();
        bank_t b;
        for (int a = 0; a < N; a++)
            b[a] = COLOR_W'(DEFAULT_PAL[DEF_PAL_W'(a >> IDX_W)][DEF_IDX_W'(a)]);
        return b;
    endfunction

    localparam bank_t BANK_INIT = bank_init();

    state_e             state, state_nx;
    logic               active, pending, pending_nx;
    logic [7:0]         frm_cnt, per_m1;
    logic [OFF_W-1:0]   offset;

    logic [LAT-1:0]     vld_pipe;
    logic [AW-1:0]      s1_addr;
    logic               s1_bank, s1_opq, s2_bank, s2_opq, px_opq;
    logic [IDX_W-1:0]   eff_idx;
    logic [IDX_W:0]     rel;
    logic [1:0][COLOR_W-1:0] rdata;

    logic [AW:0]        cp_rd;
    logic [AW-1:0]      cp_waddr;
    logic               cp_wvld, cp_src, cp_go, cp_last, host_we;

    // Cycling remap of the lookup index
    always_comb begin
        eff_idx = bus.i_px_idx;
        rel     = '0;
        if (bus.i_cyc_en && bus.i_px_idx >= IDX_W'(CYC_LO) && bus.i_px_idx <= IDX_W'(CYC_HI)) begin
            rel = {1'b0, bus.i_px_idx} - (IDX_W+1)'(CYC_LO) + (IDX_W+1)'(offset);
            if (rel >= (IDX_W+1)'(CYC_L)) rel = rel - (IDX_W+1)'(CYC_L);
            eff_idx = IDX_W'(rel) + IDX_W'(CYC_LO);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            s1_addr  <= '0;
            s1_bank  <= 1'b0;
            s1_opq   <= 1'b0;
            s2_bank  <= 1'b0;
            s2_opq   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-2:0], bus.i_px_valid};
            s1_addr  <= {bus.i_px_pal, eff_idx};
            s1_bank  <= active;
            s1_opq   <= bus.i_px_idx != IDX_W'(TRANSPARENT_IDX);
            s2_bank  <= s1_bank;
            s2_opq   <= s1_opq;
        end
    end

    assign px_opq          = vld_pipe[LAT-1] & s2_opq;
    assign bus.o_px_valid  = vld_pipe[LAT-1];
    assign bus.o_px_opaque = px_opq;
    assign bus.o_px_color  = px_opq ? rdata[s2_bank] : '0;

    // Copy source is the bank that becomes active; its first read is issued
    // during FLIP. A host write landing in FLIP can only race entry 0, which
    // is the transparent slot and never visible.
    assign cp_src  = active ^ (state == FLIP);
    assign cp_go   = (state != IDLE) && !cp_rd[AW] && !(vld_pipe[0] && s1_bank == cp_src);
    assign cp_last = cp_wvld && (cp_waddr == AW'(N-1));
    assign host_we = bus.i_wr_en && (state != COPY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cp_rd    <= '0;
            cp_wvld  <= 1'b0;
            cp_waddr <= '0;
        end else begin
            if (state == IDLE) cp_rd <= '0;
            else if (cp_go)    cp_rd <= cp_rd + 1'b1;
            cp_wvld  <= cp_go;
            cp_waddr <= cp_rd[AW-1:0];
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic          shadow, we;
        logic [AW-1:0] waddr, raddr;
        logic [COLOR_W-1:0] wdata;

        assign shadow = (active != 1'(b));
        assign we     = shadow && (host_we || cp_wvld);
        assign waddr  = cp_wvld ? cp_waddr : {bus.i_wr_pal, bus.i_wr_idx};
        assign wdata  = cp_wvld ? rdata[active] : bus.i_wr_color;
        assign raddr  = (vld_pipe[0] && s1_bank == 1'(b)) ? s1_addr : cp_rd[AW-1:0];

        pal_bank_ram #(.AW(AW), .DW(COLOR_W), .INIT(BANK_INIT)) u_ram (
            .i_clk (i_clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (raddr),
            .rdata (rdata[b])
        );
    end

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        case (state)
            IDLE: begin
                pending_nx = pending | bus.i_commit;
                if ((pending | bus.i_commit) && bus.i_frame_start) state_nx = FLIP;
            end
            FLIP: begin
                pending_nx = bus.i_commit;
                state_nx   = COPY;
            end
            COPY: begin
                pending_nx = pending | bus.i_commit;
                if (cp_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
            active  <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            if (state == FLIP) active <= ~active;
        end
    end

    assign bus.o_wr_ready = (state != COPY);
    assign bus.o_busy     = pending | (state != IDLE);

    // Frame counter runs regardless of enable; only the offset is gated
    assign per_m1 = (bus.i_cyc_period == 8'd0) ? 8'd0 : bus.i_cyc_period - 8'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frm_cnt <= '0;
            offset  <= '0;
        end else if (bus.i_frame_start) begin
            if (frm_cnt >= per_m1) begin
                frm_cnt <= '0;
                if (bus.i_cyc_en)
                    offset <= (offset == OFF_W'(CYC_L-1)) ? '0 : offset + OFF_W'(1);
            end else begin
                frm_cnt <= frm_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed bench for sprite_palette_lut: lookups, double-buffered flips,
// copy-back, colour cycling and reset during copy.
module tb_sprite_palette_lut;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    sprite_palette_lut_if bus ();

    sprite_palette_lut dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [2:0] p, input logic [3:0] i,
                        input logic [23:0] ec, input logic eo);
        bus.i_px_valid = 1'b1;
        bus.i_px_pal   = p;
        bus.i_px_idx   = i;
        tick();
        bus.i_px_valid = 1'b0;
        chk({tag, "_lat"}, 32'(bus.o_px_valid), 32'd0);
        tick();
        chk({tag, "_vld"}, 32'(bus.o_px_valid), 32'd1);
        chk({tag, "_col"}, 32'(bus.o_px_color), 32'(ec));
        chk({tag, "_opq"}, 32'(bus.o_px_opaque), 32'(eo));
    endtask

    task automatic write(input logic [2:0] p, input logic [3:0] i, input logic [23:0] c);
        bus.i_wr_en    = 1'b1;
        bus.i_wr_pal   = p;
        bus.i_wr_idx   = i;
        bus.i_wr_color = c;
        tick();
        bus.i_wr_en    = 1'b0;
    endtask

    task automatic pulse_fs();
        bus.i_frame_start = 1'b1;
        tick();
        bus.i_frame_start = 1'b0;
    endtask

    task automatic commit();
        bus.i_commit = 1'b1;
        tick();
        bus.i_commit = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.o_wr_ready && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.o_wr_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.i_frame_start = 0; bus.i_wr_en = 0; bus.i_wr_pal = '0; bus.i_wr_idx = '0;
        bus.i_wr_color = '0; bus.i_commit = 0; bus.i_cyc_en = 0; bus.i_cyc_period = 8'd0;
        bus.i_px_valid = 0; bus.i_px_pal = '0; bus.i_px_idx = '0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // reset state
        chk("rst_vld",   32'(bus.o_px_valid),  32'd0);
        chk("rst_col",   32'(bus.o_px_color),  32'd0);
        chk("rst_opq",   32'(bus.o_px_opaque), 32'd0);
        chk("rst_ready", 32'(bus.o_wr_ready),  32'd1);
        chk("rst_busy",  32'(bus.o_busy),      32'd0);

        // default contents and transparent index
        look("p0i1", 3'd0, 4'd1, 24'h01FE5B, 1'b1);
        look("p0i0", 3'd0, 4'd0, 24'h000000, 1'b0);

        // shadow write is invisible until a flip
        write(3'd2, 4'd5, 24'h123456);
        look("p2i5_old", 3'd2, 4'd5, 24'h25DA7F, 1'b1);
        commit();
        chk("pend_busy", 32'(bus.o_busy), 32'd1);
        pulse_fs();
        chk("flip_ready", 32'(bus.o_wr_ready), 32'd1);
        tick();
        n = 0;
        while (!bus.o_wr_ready && n < 1000) begin
            n++;
            tick();
        end
        chk("copy_len", 32'(n), 32'd128);
        chk("idle_busy", 32'(bus.o_busy), 32'd0);
        look("p2i5_new", 3'd2, 4'd5, 24'h123456, 1'b1);

        // writes during copy are dropped; lookup during copy still served
        commit();
        pulse_fs();
        tick();
        chk("copy_busy", 32'(bus.o_busy), 32'd1);
        write(3'd2, 4'd5, 24'hABCDEF);
        write(3'd3, 4'd7, 24'h777777);
        look("copy_look", 3'd2, 4'd5, 24'h123456, 1'b1);
        wait_ready("copy2_end");
        look("p2i5_kept", 3'd2, 4'd5, 24'h123456, 1'b1);
        look("p3i7_kept", 3'd3, 4'd7, 24'h37C86D, 1'b1);

        // commit and frame start in the same cycle flip immediately
        bus.i_commit = 1'b1;
        bus.i_frame_start = 1'b1;
        tick();
        bus.i_commit = 1'b0;
        bus.i_frame_start = 1'b0;
        chk("same_busy", 32'(bus.o_busy), 32'd1);
        tick();
        chk("same_copy", 32'(bus.o_wr_ready), 32'd0);

        // commit and frame start during copy: flip waits for a later frame
        repeat (5) tick();
        commit();
        pulse_fs();
        wait_ready("copy3_end");
        chk("late_pend", 32'(bus.o_busy), 32'd1);
        repeat (3) tick();
        chk("no_flip", 32'(bus.o_wr_ready), 32'd1);
        write(3'd5, 4'd3, 24'h5A5A5A);
        look("p5i3_old", 3'd5, 4'd3, 24'h53AC09, 1'b1);
        pulse_fs();
        tick();
        chk("late_copy", 32'(bus.o_wr_ready), 32'd0);
        wait_ready("copy4_end");
        look("p5i3_new", 3'd5, 4'd3, 24'h5A5A5A, 1'b1);
        chk("late_idle", 32'(bus.o_busy), 32'd0);

        // colour cycling, period 2
        bus.i_cyc_period = 8'd2;
        bus.i_cyc_en = 1'b1;
        pulse_fs();
        tick();
        pulse_fs();
        tick();
        look("cyc_i13", 3'd0, 4'd13, 24'h01FE5B, 1'b1);
        look("cyc_i1",  3'd0, 4'd1,  24'h02FD58, 1'b1);
        look("cyc_i12", 3'd0, 4'd12, 24'h0DF257, 1'b1);
        look("cyc_i14", 3'd0, 4'd14, 24'h0EF154, 1'b1);
        look("cyc_i0",  3'd0, 4'd0,  24'h000000, 1'b0);
        bus.i_cyc_en = 1'b0;
        look("cyc_off", 3'd0, 4'd13, 24'h0DF257, 1'b1);
        bus.i_cyc_en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            pulse_fs();
            tick();
        end
        look("cyc26_i13", 3'd0, 4'd13, 24'h0DF257, 1'b1);
        look("cyc26_i1",  3'd0, 4'd1,  24'h01FE5B, 1'b1);

        // reset in the middle of a copy
        bus.i_cyc_en = 1'b0;
        bus.i_cyc_period = 8'd0;
        write(3'd4, 4'd9, 24'hFACE01);
        commit();
        pulse_fs();
        tick();
        repeat (10) tick();
        chk("pre_rst_copy", 32'(bus.o_wr_ready), 32'd0);
        bus.i_px_valid = 1'b1;
        bus.i_px_pal = 3'd4;
        bus.i_px_idx = 4'd9;
        tick();
        bus.i_px_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("mrst_vld",   32'(bus.o_px_valid),  32'd0);
        chk("mrst_col",   32'(bus.o_px_color),  32'd0);
        chk("mrst_opq",   32'(bus.o_px_opaque), 32'd0);
        chk("mrst_ready", 32'(bus.o_wr_ready),  32'd1);
        chk("mrst_busy",  32'(bus.o_busy),      32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("post_ready", 32'(bus.o_wr_ready), 32'd1);
        look("post_p4i9", 3'd4, 4'd9, 24'h49B613, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
